if_id_inst_queue: RTL
=====================

Name: if_id_inst_queue

Overview:
- Instruction queue between the fetch stage (PC plus instruction memory read) and the decode stage.
- Buffers fetched {pc, inst} pairs in a small circular FIFO and decouples fetch from decode stalls through valid/ready handshakes.
- Supports a branch-resolution flush that can preserve exactly one MIPS32 branch delay-slot instruction.

Parameters:
- W, 32 (`WORD_WIDTH), width of pc and instruction words
- DEPTH, 4, number of queue entries; power of two, at least 2
- AW, $clog2(DEPTH), pointer width (derived; must not be overridden)

Ports:
- clk  input  1  clock; all state updates on posedge
- rst  input  1  asynchronous, active-low reset
- in_valid  input  1  fetch presents a valid {in_pc, in_inst}
- in_ready  output  1  queue accepts a push this cycle
- in_pc  input  W  pc of fetched instruction
- in_inst  input  W  fetched instruction word
- out_valid  output  1  head entry is valid for decode
- out_ready  input  1  decode consumes head (deasserted on decode stall)
- out_pc  output  W  pc of head entry
- out_inst  output  W  instruction of head entry
- flush  input  1  discard queued instructions (branch taken / redirect)
- flush_keep_slot  input  1  qualifies flush: keep one delay-slot entry
- count  output  AW+1  current occupancy, 0..DEPTH

Behaviour:
- Reset (rst=0, asynchronous): rd_ptr=0, wr_ptr=0, count=0. Storage contents are don't-care.
  - Outputs during reset: out_valid=0, in_ready=1, out_pc=0, out_inst=0.
- Handshake and output values:
  - push = in_valid & in_ready; pop = out_valid & out_ready.
  - in_ready = (count < DEPTH). It is registered-state only, with no combinational path from out_ready.
  - out_valid = (count != 0).
  - out_pc and out_inst read storage[rd_ptr] combinationally. They are forced to 0 (NOP) when out_valid=0.
- Latency: a pushed entry appears on out_* in the next cycle. There is no same-cycle bypass, even when the queue is empty.
- Normal update (flush=0):
  - On push: write storage[wr_ptr] and set wr_ptr += 1 (mod DEPTH).
  - On pop: rd_ptr += 1 (mod DEPTH).
  - count += push - pop. Simultaneous push and pop leaves count unchanged.
  - Pointers wrap naturally at DEPTH.
- Full: in_ready=0, so an in_valid push is not accepted; fetch must hold its pc. A pop while full raises in_ready in the next cycle, not the same cycle.
- Empty: out_valid=0, and out_ready is ignored.
- Flush with flush_keep_slot=0:
  - Next state is count=0, rd_ptr=wr_ptr=0.
  - Any same-cycle push is discarded. The same-cycle pop still completes, because decode took the head.
- Flush with flush_keep_slot=1 (delay-slot preservation):
  - Let rem = count - pop.
  - If rem >= 1: keep storage[rd_ptr + pop], i.e. the entry following the consumed branch. Next state: rd_ptr = rd_ptr + pop, wr_ptr = rd_ptr + pop + 1, count=1. Same-cycle push is discarded.
  - Else if push: the incoming entry becomes the sole entry. Write storage[wr_ptr], rd_ptr=wr_ptr, wr_ptr+1, count=1.
  - Else: count=0 and rd_ptr=wr_ptr=0. Fetch must then deliver the delay slot after the redirect.
- Priority: reset > flush > push/pop.
- in_ready during flush follows its normal formula; fetch ignores it on redirect.
- Reset asserted mid-operation clears the queue immediately (asynchronous). Deassertion is expected synchronous to clk, handled externally.
- count never exceeds DEPTH and never underflows. The bench asserts this every cycle.

Test Plan:
- Reset then stream: rst low→high; push pc=0x0,0x4,0x8 with inst=0x11,0x22,0x33, out_ready=1 → out_valid rises 1 cycle after the first push; out_pc sequence 0x0,0x4,0x8 in order; count stays ≤1.
- Fill and stall: out_ready=0, push 4 entries pc=0x100..0x10C → count=4, in_ready=0; 5th in_valid not accepted. Set out_ready=1 for one cycle → out_pc=0x100 popped, in_ready=1 the following cycle.
- Wrap-around: 10 pushes and pops at mixed rates with pc=0x200+4k → pops return exactly 0x200..0x224 in order, no duplicates or losses across pointer wrap.
- Flush without keep: queue holds pc 0x300,0x304,0x308; flush=1, flush_keep_slot=0, out_ready=1, push pc=0x30C in the same cycle → next cycle count=0, out_valid=0, out_inst=0.
- Flush keep slot: queue holds pc 0x400 (branch),0x404,0x408; out_ready=1, flush=1, flush_keep_slot=1 → next cycle count=1, out_pc=0x404. Repeat with only 0x400 queued plus push 0x404 the same cycle → count=1, out_pc=0x404.
- Async reset mid-stream: count=3, drop rst between clock edges → out_valid=0, count=0, in_ready=1 immediately, before the next clk edge.

Source files
------------

// File: rtl/if_id_inst_queue_if.sv
// Fetch-to-decode handshake bundle for the instruction queue.
// slave is the queue side, master is the fetch/decode environment side.
interface if_id_inst_queue_if #(
    parameter int W     = 32,
    parameter int DEPTH = 4
);
    localparam int AW = $clog2(DEPTH);

    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_pc;
    logic [W-1:0]  in_inst;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_pc;
    logic [W-1:0]  out_inst;
    logic          flush;
    logic          flush_keep_slot;
    logic [AW:0]   count;

    modport slave (
        input  in_valid, in_pc, in_inst, out_ready, flush, flush_keep_slot,
        output in_ready, out_valid, out_pc, out_inst, count
    );

    modport master (
        output in_valid, in_pc, in_inst, out_ready, flush, flush_keep_slot,
        input  in_ready, out_valid, out_pc, out_inst, count
    );
endinterface

// File: rtl/if_id_inst_queue.sv
// Circular {pc, inst} FIFO between fetch and decode, with branch flush
// that can preserve a single delay-slot instruction.
module if_id_inst_queue #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    if_id_inst_queue_if.slave   q
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [W-1:0]  r_pc_mem   [DEPTH];
    logic [W-1:0]  r_inst_mem [DEPTH];
    logic [AW-1:0] r_rd;
    logic [AW-1:0] r_wr;
    logic [CW-1:0] r_count;

    logic          w_in_ready;
    logic          w_out_valid;
    logic          w_push;
    logic          w_pop;
    logic [CW-1:0] w_rem;
    logic          w_we;
    logic [AW-1:0] w_rd_nxt;
    logic [AW-1:0] w_wr_nxt;
    logic [CW-1:0] w_count_nxt;

    assign w_in_ready  = (r_count < FULL_CNT);
    assign w_out_valid = (r_count != '0);
    assign w_push      = q.in_valid & w_in_ready;
    assign w_pop       = w_out_valid & q.out_ready;
    // Entries left once the branch at the head has been consumed this cycle.
    assign w_rem       = r_count - CW'(w_pop);

    always_comb begin
        w_we        = w_push;
        w_rd_nxt    = r_rd + AW'(w_pop);
        w_wr_nxt    = r_wr + AW'(w_push);
        w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
        if (q.flush) begin
            w_we        = 1'b0;
            w_rd_nxt    = '0;
            w_wr_nxt    = '0;
            w_count_nxt = '0;
            if (q.flush_keep_slot) begin
                if (w_rem != '0) begin
                    w_rd_nxt    = r_rd + AW'(w_pop);
                    w_wr_nxt    = r_rd + AW'(w_pop) + AW'(1);
                    w_count_nxt = CW'(1);
                end else if (w_push) begin
                    w_we        = 1'b1;
                    w_rd_nxt    = r_wr;
                    w_wr_nxt    = r_wr + AW'(1);
                    w_count_nxt = CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            r_rd    <= w_rd_nxt;
            r_wr    <= w_wr_nxt;
            r_count <= w_count_nxt;
        end
    end

    // Storage needs no reset: it is never observed while count is zero.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_pc_mem[r_wr]   <= q.in_pc;
            r_inst_mem[r_wr] <= q.in_inst;
        end
    end

    assign q.in_ready  = w_in_ready;
    assign q.out_valid = w_out_valid;
    assign q.out_pc    = w_out_valid ? r_pc_mem[r_rd]   : '0;
    assign q.out_inst  = w_out_valid ? r_inst_mem[r_rd] : '0;
    assign q.count     = r_count;
endmodule
